// File: rtl/tdc_pkg.sv
// Shared types for the TDC measurement sequencer and its result register.
package tdc_pkg;

   // Default widths; the result struct is built on these.
   localparam int TDC_COARSE_W = 8;
   localparam int TDC_FINE_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ARMED,
      ST_COUNT,
      ST_DONE
   } tdc_state_e;

   typedef struct packed {
      logic [TDC_COARSE_W-1:0] coarse;
      logic [TDC_FINE_W-1:0]   fine_start;
      logic [TDC_FINE_W-1:0]   fine_stop;
      logic                    timeout;
   } tdc_result_t;

endpackage

// File: rtl/tdc_result_reg.sv
// Result holding register with valid/ready handshake. Shared with the readout mux.
module tdc_result_reg
   import tdc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        load,
   input  tdc_result_t load_data,
   input  logic        ready,
   output logic        valid,
   output tdc_result_t data
);

   // Capture on load, hold until consumed; clr discards any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arm, settle, count start->stop, hand off result.
// COARSE_W/FINE_W must match the widths of tdc_result_t in tdc_pkg.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int COARSE_W = TDC_COARSE_W,
   parameter int FINE_W   = TDC_FINE_W,
   parameter int SETTLE   = 4,
   parameter int TIMEOUT  = 200
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                cont_i,
   input  logic                meas_req_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic [FINE_W-1:0]   fine_start_i,
   input  logic [FINE_W-1:0]   fine_stop_i,
   output logic                arm_o,
   output logic                busy_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [COARSE_W-1:0] res_coarse_o,
   output logic [FINE_W-1:0]   res_fine_start_o,
   output logic [FINE_W-1:0]   res_fine_stop_o,
   output logic                res_timeout_o
);

   localparam logic [3:0]          SETTLE_LD = 4'(SETTLE - 1);
   localparam logic [COARSE_W-1:0] TMO_CNT   = COARSE_W'(TIMEOUT);

   tdc_state_e          state;
   logic [3:0]          settle_cnt;
   logic [COARSE_W-1:0] coarse;
   logic [COARSE_W-1:0] coarse_inc;
   logic [FINE_W-1:0]   fine_start_q;
   logic                cap_both;
   logic                cap_stop;
   logic                cap_tmo;
   logic                res_load;
   logic                res_clr;
   logic                res_valid;
   logic                hs;
   tdc_result_t         res_new;
   tdc_result_t         res_q;

   // Terminating events and the result they produce. coarse never exceeds
   // TIMEOUT-1 while counting, so the increment cannot wrap.
   always_comb begin
      coarse_inc         = coarse + COARSE_W'(1);
      cap_both           = (state == ST_ARMED) && start_i && stop_i;
      cap_stop           = (state == ST_COUNT) && stop_i;
      cap_tmo            = (state == ST_COUNT) && !stop_i && (coarse_inc == TMO_CNT);
      res_load           = ena && (cap_both || cap_stop || cap_tmo);
      res_clr            = !ena;
      hs                 = res_valid && res_ready_i;
      res_new            = '0;
      res_new.coarse     = cap_both ? '0 : coarse_inc;
      res_new.fine_start = cap_both ? fine_start_i : fine_start_q;
      res_new.fine_stop  = (cap_both || cap_stop) ? fine_stop_i : '0;
      res_new.timeout    = cap_tmo;
   end

   // Sequencer FSM with counters and registered arm/busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         coarse       <= '0;
         fine_start_q <= '0;
         arm_o        <= 1'b0;
         busy_o       <= 1'b0;
      end else if (!ena) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         coarse       <= '0;
         fine_start_q <= '0;
         arm_o        <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (meas_req_i) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SETTLE_LD;
                  arm_o      <= 1'b1;
                  busy_o     <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) state <= ST_ARMED;
               else settle_cnt <= settle_cnt - 4'd1;
            end
            ST_ARMED: begin
               if (start_i) begin
                  fine_start_q <= fine_start_i;
                  coarse       <= '0;
                  if (stop_i) begin
                     state <= ST_DONE;
                     arm_o <= 1'b0;
                  end else begin
                     state <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               coarse <= coarse_inc;
               if (cap_stop || cap_tmo) begin
                  state <= ST_DONE;
                  arm_o <= 1'b0;
               end
            end
            ST_DONE: begin
               if (hs) begin
                  coarse <= '0;
                  if (cont_i) begin
                     state      <= ST_SETTLE;
                     settle_cnt <= SETTLE_LD;
                     arm_o      <= 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     busy_o <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               arm_o  <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   tdc_result_reg u_result (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (res_clr),
      .load      (res_load),
      .load_data (res_new),
      .ready     (res_ready_i),
      .valid     (res_valid),
      .data      (res_q)
   );

   assign res_valid_o      = res_valid;
   assign res_coarse_o     = res_q.coarse;
   assign res_fine_start_o = res_q.fine_start;
   assign res_fine_stop_o  = res_q.fine_stop;
   assign res_timeout_o    = res_q.timeout;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomized bench for tdc_meas_ctrl against a measurement-level reference model.
module tb_tdc_meas_ctrl;

   localparam int CW      = 8;
   localparam int FW      = 5;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 200;

   logic          clk = 1'b0;
   logic          rst_n, ena, cont_i, meas_req_i, start_i, stop_i, res_ready_i;
   logic [FW-1:0] fine_start_i, fine_stop_i, res_fine_start_o, res_fine_stop_o;
   logic          arm_o, busy_o, res_valid_o, res_timeout_o;
   logic [CW-1:0] res_coarse_o;
   logic [21:0]   all_out;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   assign all_out = {arm_o, busy_o, res_valid_o, res_coarse_o,
                     res_fine_start_o, res_fine_stop_o, res_timeout_o};

   tdc_meas_ctrl #(.COARSE_W(CW), .FINE_W(FW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cont_i(cont_i), .meas_req_i(meas_req_i),
      .start_i(start_i), .stop_i(stop_i), .fine_start_i(fine_start_i),
      .fine_stop_i(fine_stop_i), .arm_o(arm_o), .busy_o(busy_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_coarse_o(res_coarse_o),
      .res_fine_start_o(res_fine_start_o), .res_fine_stop_o(res_fine_stop_o),
      .res_timeout_o(res_timeout_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      start_i = 0; stop_i = 0; meas_req_i = 0; res_ready_i = 0;
   endtask

   // Issue a single-shot request from IDLE; arm must rise one cycle later.
   task automatic start_single;
      n_cmp++;
      if ({arm_o, busy_o} !== 2'b00) begin
         n_err++; $display("FAIL idle_before_req: arm/busy=%b want 00", {arm_o, busy_o});
      end
      meas_req_i = 1; tick; meas_req_i = 0;
      n_cmp++;
      if (arm_o !== 1'b1) begin
         n_err++; $display("FAIL arm_rise: arm=%b want 1", arm_o);
      end
   endtask

   // One measurement from the cycle arm_o rose. Start comes d cycles after
   // ARMED, stop len cycles after start (len > TIMEOUT: no stop). Stray
   // start/stop pulses and garbage fine codes are injected where ignored.
   task automatic run_meas(input int d, input int len, input logic [FW-1:0] fs,
                           input logic [FW-1:0] fp, input int rdly, input bit cont);
      bit            tmo, busy_bad, hold_bad;
      int            cl, cs0, ev, v, c, arm_n;
      logic [CW-1:0] e_coarse;
      logic [FW-1:0] e_fstop;
      tmo = (len > TIMEOUT);
      cl  = tmo ? TIMEOUT : len;
      cs0 = SETTLE + d;
      ev  = cs0 + 1 + cl;
      e_coarse = CW'(cl);
      e_fstop  = tmo ? '0 : fp;
      v = -1; c = 0; arm_n = 0; busy_bad = 0; hold_bad = 0;
      while (v < 0 && c <= ev + 4) begin
         if (res_valid_o === 1'b1) v = c;
         else begin
            if (arm_o === 1'b1) arm_n++;
            if (busy_o !== 1'b1) busy_bad = 1;
            start_i = 0; stop_i = 0;
            fine_start_i = FW'($urandom); fine_stop_i = FW'($urandom);
            cont_i = 1'($urandom); res_ready_i = 1'($urandom);
            if (c == SETTLE - 1) start_i = 1;
            if (c < cs0) stop_i = 1'($urandom);
            if (c == cs0) begin start_i = 1; fine_start_i = fs; end
            if (c > cs0 && c < cs0 + cl) start_i = 1'($urandom);
            if (!tmo && c == cs0 + len) begin stop_i = 1; fine_stop_i = fp; end
            tick;
            c++;
         end
      end
      start_i = 0; stop_i = 0; res_ready_i = 0; cont_i = cont;
      n_cmp++;
      if (v != ev) begin
         n_err++; $display("FAIL valid_rise: got cycle %0d want %0d", v, ev);
      end
      if (v < 0) begin
         ena = 0; tick; ena = 1;
         return;
      end
      n_cmp++;
      if (arm_n != ev) begin
         n_err++; $display("FAIL arm_cycles: got %0d want %0d", arm_n, ev);
      end
      n_cmp++;
      if (busy_bad) begin
         n_err++; $display("FAIL busy_meas: busy dropped, want 1 throughout");
      end
      n_cmp++;
      if (arm_o !== 1'b0) begin
         n_err++; $display("FAIL arm_done: arm=%b want 0", arm_o);
      end
      n_cmp++;
      if ({res_coarse_o, res_fine_start_o, res_fine_stop_o, res_timeout_o} !==
          {e_coarse, fs, e_fstop, tmo}) begin
         n_err++;
         $display("FAIL result: got c=%0d fs=%0d fp=%0d to=%b want c=%0d fs=%0d fp=%0d to=%b",
                  res_coarse_o, res_fine_start_o, res_fine_stop_o, res_timeout_o,
                  e_coarse, fs, e_fstop, tmo);
      end
      for (int r = 0; r < rdly; r++) begin
         tick;
         if (res_valid_o !== 1'b1 || arm_o !== 1'b0 ||
             {res_coarse_o, res_fine_start_o, res_fine_stop_o, res_timeout_o} !==
             {e_coarse, fs, e_fstop, tmo}) hold_bad = 1;
      end
      if (rdly > 0) begin
         n_cmp++;
         if (hold_bad) begin
            n_err++; $display("FAIL hold: result/valid/arm changed while ready low");
         end
      end
      res_ready_i = 1; tick; res_ready_i = 0;
      n_cmp++;
      if (res_valid_o !== 1'b0) begin
         n_err++; $display("FAIL valid_drop: valid=%b want 0", res_valid_o);
      end
      n_cmp++;
      if ({arm_o, busy_o} !== {cont, cont}) begin
         n_err++; $display("FAIL rearm: arm/busy=%b want %b", {arm_o, busy_o}, {cont, cont});
      end
   endtask

   task automatic test_reset;
      rst_n = 0; ena = 1; cont_i = 0; quiet(); fine_start_i = '0; fine_stop_i = '0;
      tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL reset: outputs=%h want 0", all_out);
      end
      repeat (2) tick;
      rst_n = 1;
      repeat (2) tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL post_reset_idle: outputs=%h want 0", all_out);
      end
   endtask

   task automatic test_basic;
      start_single(); run_meas(2, 10, 5'd5, 5'd17, 0, 0);
   endtask

   task automatic test_timeout;
      start_single(); run_meas(1, TIMEOUT + 50, 5'd9, 5'd3, 5, 0);
      start_single(); run_meas(0, TIMEOUT, 5'd31, 5'd1, 0, 0);
      start_single(); run_meas(3, TIMEOUT - 1, 5'd0, 5'd30, 0, 0);
   endtask

   task automatic test_same_cycle;
      start_single(); run_meas(0, 0, 5'd12, 5'd21, 0, 0);
      start_single(); run_meas(3, 0, 5'd7, 5'd8, 1, 0);
      start_single(); run_meas(0, 1, 5'd2, 5'd4, 0, 0);
   endtask

   task automatic test_stray_stop;
      bit vbad, abad;
      vbad = 0; abad = 0;
      start_single();
      for (int c = 0; c < SETTLE + 10; c++) begin
         if (res_valid_o !== 1'b0) vbad = 1;
         if (arm_o !== 1'b1) abad = 1;
         stop_i = 1; fine_stop_i = FW'($urandom);
         tick;
      end
      stop_i = 0;
      n_cmp++;
      if (vbad) begin
         n_err++; $display("FAIL stray_stop_result: valid seen, want none");
      end
      n_cmp++;
      if (abad) begin
         n_err++; $display("FAIL stray_stop_arm: arm dropped, want held");
      end
      ena = 0; tick; ena = 1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL stray_abort: outputs=%h want 0", all_out);
      end
   endtask

   task automatic test_continuous;
      start_single();
      run_meas(1, 7, 5'd19, 5'd6, 20, 1);
      run_meas(0, 3, 5'd11, 5'd29, 0, 1);
      run_meas(2, 5, 5'd1, 5'd2, 2, 0);
   endtask

   task automatic test_back_to_back;
      bit chained, cont;
      int len;
      chained = 0;
      for (int i = 0; i < 10; i++) begin
         if (!chained) start_single();
         cont = (i < 9) ? 1'($urandom) : 1'b0;
         len  = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 + int'($urandom_range(0, 9))
                                            : int'($urandom_range(0, 25));
         run_meas(int'($urandom_range(0, 5)), len, FW'($urandom), FW'($urandom),
                  int'($urandom_range(0, 3)), cont);
         chained = cont;
      end
   endtask

   task automatic test_ena_abort;
      start_single();
      repeat (SETTLE) tick;
      start_i = 1; fine_start_i = FW'($urandom); tick; start_i = 0;
      repeat (3) tick;
      ena = 0; tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL ena_abort: outputs=%h want 0", all_out);
      end
      meas_req_i = 1; repeat (3) tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL ena_low_req: outputs=%h want 0", all_out);
      end
      ena = 1; meas_req_i = 0; stop_i = 1; tick; stop_i = 0; repeat (3) tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL no_result_after_abort: outputs=%h want 0", all_out);
      end
   endtask

   task automatic test_rst_done;
      start_single();
      repeat (SETTLE) tick;
      start_i = 1; stop_i = 1; fine_start_i = 5'd13; fine_stop_i = 5'd14;
      tick;
      start_i = 0; stop_i = 0;
      n_cmp++;
      if ({res_valid_o, res_coarse_o, res_fine_start_o, res_fine_stop_o} !==
          {1'b1, 8'd0, 5'd13, 5'd14}) begin
         n_err++; $display("FAIL same_cycle_done: v=%b c=%0d fs=%0d fp=%0d want 1/0/13/14",
                           res_valid_o, res_coarse_o, res_fine_start_o, res_fine_stop_o);
      end
      #1 rst_n = 0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL rst_async_done: outputs=%h want 0", all_out);
      end
      tick; rst_n = 1; repeat (2) tick;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL post_rst_idle: outputs=%h want 0", all_out);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_same_cycle();
      test_stray_stop();
      test_continuous();
      test_back_to_back();
      test_ena_abort();
      test_rst_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the on-chip time-to-digital converter. It arms the delay line and waits a settle interval. It then accepts one start/stop pulse pair and counts whole clock periods between them. It packs the coarse count with both fine delay-line codes into a single result, delivered over a valid/ready handshake. It sits between the TDC analog front end (start/stop synchronisers, fine-code encoders) and the readout logic driving `uo_out`/`uio_out`.

## Interface
Parameters:
- `COARSE_W`, 8: coarse counter width.
- `FINE_W`, 5: width of each fine code.
- `SETTLE`, 4: clock cycles the delay line is held armed before a start is accepted; 1 to 15.
- `TIMEOUT`, 200: coarse count at which a measurement aborts; must be less than 2^COARSE_W.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ena`, in, 1: block enable. Low aborts any measurement and forces IDLE.
- `cont_i`, in, 1: 1 selects continuous re-arm; 0 selects single shot. Sampled on leaving DONE.
- `meas_req_i`, in, 1: single-shot request, level-sensitive in IDLE.
- `start_i`, in, 1: synchronised start pulse, one cycle wide.
- `stop_i`, in, 1: synchronised stop pulse, one cycle wide.
- `fine_start_i`, in, FINE_W: fine code, valid in the `start_i` cycle.
- `fine_stop_i`, in, FINE_W: fine code, valid in the `stop_i` cycle.
- `arm_o`, out, 1: delay-line enable.
- `busy_o`, out, 1: high in any state other than IDLE.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: result consumed.
- `res_coarse_o`, out, COARSE_W: coarse count.
- `res_fine_start_o`, out, FINE_W: captured start fine code.
- `res_fine_stop_o`, out, FINE_W: captured stop fine code.
- `res_timeout_o`, out, 1: measurement timed out.

## Operation
- States: IDLE, SETTLE, ARMED, COUNT, DONE.
- IDLE:
  - arm_o=0.
  - meas_req_i=1 with ena=1 → SETTLE; settle counter loads SETTLE-1.
- SETTLE:
  - arm_o=1; counter decrements.
  - At 0 → ARMED.
  - start_i/stop_i ignored.
- ARMED:
  - arm_o=1; stop_i alone is ignored.
  - start_i → COUNT; latch fine_start_i; coarse=0.
  - start_i and stop_i in the same cycle → DONE with coarse=0, both fine codes latched, timeout=0.
- COUNT:
  - arm_o=1; coarse increments by 1 every cycle; start_i is ignored.
  - stop_i → DONE; latch fine_stop_i; result coarse = value after this cycle's increment. Example: stop one cycle after start gives coarse=1.
  - If coarse reaches TIMEOUT with no stop → DONE; res_timeout_o=1; res_coarse_o=TIMEOUT; fine_stop=0.
  - Stop in the exact cycle coarse reaches TIMEOUT counts as a normal stop (timeout=0).
- DONE:
  - arm_o=0; res_valid_o=1; result registers stable.
  - Handshake completes in the cycle res_valid_o & res_ready_i. Next state: SETTLE if cont_i=1, else IDLE.
  - res_valid_o drops the cycle after the handshake.
- Coarse counter saturates at TIMEOUT and never wraps.
- ena=0 in any state → IDLE next cycle. arm_o, res_valid_o and all counters clear; any pending result is discarded.
- Reset: all outputs 0 and state IDLE, including mid-measurement.

## Timing
- arm_o rises the cycle after the request is sampled in IDLE.
- First start accepted SETTLE cycles after arm_o rises.
- res_valid_o rises the cycle after the stop or timeout cycle (registered outputs).
- Re-arm latency in continuous mode: 1 + SETTLE cycles from the handshake to ARMED.
- No combinational path from res_ready_i or start/stop to any output.

## Structure
- Shared package `tdc_pkg`:
  - state enum `tdc_state_e`.
  - result struct `tdc_result_t` holding coarse, fine_start, fine_stop and timeout.
  - default widths COARSE_W and FINE_W.
- Sub-module `tdc_result_reg`: holds the result and the valid/ready handshake, so the readout mux reuses it.
- The FSM and counters stay in the top.

## Test plan
- SETTLE=4, meas_req pulse; start 2 cycles after ARMED with fine_start=5; stop 10 cycles later with fine_stop=17 → result coarse=10, fine 5/17, timeout=0; arm_o high for exactly 4+2+10+1 cycles.
- Start with no stop, TIMEOUT=200 → res_timeout_o=1, coarse=200, fine_stop=0; valid held until ready.
- Start and stop in the same ARMED cycle → coarse=0. Stop during SETTLE or ARMED alone → ignored, no result.
- cont_i=1, ready held low for 20 cycles in DONE → result stable, arm_o=0. After ready, arm_o returns 1 cycle later; a second measurement completes.
- ena dropped during COUNT and rst_n asserted during DONE → IDLE next cycle (ena) or immediately (rst_n); all outputs 0; no result emitted.
